// File: rtl/mul_div_alu.sv
// ============================================================================
//  mul_div_alu : combinational ALU plus multi-cycle multiply/divide unit with
//                HI/LO result registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_alu #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Op,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   input  logic [2:0]       MdOp,
   input  logic             Start,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam int HALF       = WIDTH / 2;

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   localparam logic [2:0] c_MD_MTHI = 3'd4;
   localparam logic [2:0] c_MD_MTLO = 3'd5;

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             w_done;
   logic             w_accept;
   logic             w_start_md;
   logic             w_ovf;
   logic [WIDTH-1:0] w_dvsr;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic [WIDTH-1:0] w_quo_s, w_rem_s;
   logic [WIDTH-1:0] w_quo_u, w_rem_u;

   // ------------------------------------------------------------------ ALU
   always_comb begin
      Result = '0;
      case (Op)
         4'd0:    Result = A & B;
         4'd1:    Result = A | B;
         4'd2:    Result = A + B;
         4'd6:    Result = A - B;
         4'd8:    Result = {B[HALF-1:0], B[WIDTH-1:HALF]};
         default: Result = '0;
      endcase
   end

   assign Zero = (A == B);

   // -------------------------------------------------------- control
   // The final busy cycle also counts as ready so back-to-back ops lose no cycle.
   assign w_done     = (state_q == c_RUN) && (cnt_q == '0);
   assign w_accept   = Start && ((state_q == c_IDLE) || w_done);
   assign w_start_md = w_accept && !MdOp[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= c_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:  if (w_start_md) state_d = c_RUN;
         c_RUN:   if (cnt_q == '0) state_d = w_start_md ? c_RUN : c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      Busy = (state_q == c_RUN);
      HI   = hi_q;
      LO   = lo_q;
   end

   // --------------------------------------------------------- datapath
   // Signed product formed from sign-extended operands; low 2*WIDTH bits match.
   assign w_prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign w_prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // Most-negative / -1 is steered to a divide by 1, giving quotient=dividend, rem=0.
   assign w_ovf   = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
   assign w_dvsr  = w_ovf ? WIDTH'(1) : b_q;
   assign w_quo_s = $signed(a_q) / $signed(w_dvsr);
   assign w_rem_s = $signed(a_q) % $signed(w_dvsr);
   assign w_quo_u = a_q / b_q;
   assign w_rem_u = a_q % b_q;

   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      hi_d  = hi_q;
      lo_d  = lo_q;

      if (state_q == c_RUN && cnt_q != '0)
         cnt_d = cnt_q - CW'(1);

      if (w_done) begin
         case (op_q)
            2'd0: {hi_d, lo_d} = w_prod_s;
            2'd1: {hi_d, lo_d} = w_prod_u;
            2'd2: if (b_q != '0) begin hi_d = w_rem_s; lo_d = w_quo_s; end
            default: if (b_q != '0) begin hi_d = w_rem_u; lo_d = w_quo_u; end
         endcase
      end

      if (w_start_md) begin
         cnt_d = MdOp[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
         op_d  = MdOp[1:0];
         a_d   = A;
         b_d   = B;
      end

      if (w_accept && MdOp == c_MD_MTHI) hi_d = A;
      if (w_accept && MdOp == c_MD_MTLO) lo_d = A;
   end

endmodule

`default_nettype wire

// File: doc/mul_div_alu.md
MUL_DIV_ALU -- requirements
Module: mul_div_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >= 8.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, Busy duration of mult/multu; >= 1.
REQ-003 SHALL have parameter DIV_CYCLES, default 10, Busy duration of div/divu; >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port A  input  WIDTH  operand A / dividend / mthi-mtlo source.
REQ-007 SHALL have port B  input  WIDTH  operand B / divisor.
REQ-008 SHALL have port Op  input  4  combinational ALU operation select.
REQ-009 SHALL have port Result  output  WIDTH  combinational ALU result.
REQ-010 SHALL have port Zero  output  1  high when A == B.
REQ-011 SHALL have port MdOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
REQ-012 SHALL have port Start  input  1  one-cycle request qualifying MdOp.
REQ-013 SHALL have port Busy  output  1  multiply/divide in progress.
REQ-014 SHALL have ports HI and LO  output  WIDTH  registered HI/LO contents.

Function
REQ-015 SHALL compute Result combinationally: Op 0 A&B, 1 A|B, 2 A+B, 6 A-B, 8 {B[WIDTH/2-1:0],B[WIDTH-1:WIDTH/2]}, all other Op 0; no latch inferred; add/sub wrap modulo 2^WIDTH.
REQ-016 SHALL drive Zero combinationally, independent of Op, Start and Busy.
REQ-017 SHALL accept a request only at an edge where Start=1 and Busy=0; Start while Busy=1 is ignored, with no effect on operation, counter or HI/LO.
REQ-018 SHALL sample A, B and MdOp at the accepting edge; later input changes do not affect the result.
REQ-019 SHALL, for accepted mthi/mtlo, write A into HI/LO at that edge; Busy stays 0.
REQ-020 SHALL, for accepted mult/multu/div/divu, set Busy=1 at that edge and hold it exactly MULT_CYCLES or DIV_CYCLES cycles respectively.
REQ-021 SHALL update HI/LO at the edge where Busy falls; the new values are visible in the first cycle with Busy=0, and a new Start is accepted at that same edge.
REQ-022 SHALL hold HI/LO stable while Busy=1.
REQ-023 SHALL form mult/multu as the full 2*WIDTH-bit signed/unsigned product: HI=upper half, LO=lower half.
REQ-024 SHALL form div/divu with LO=quotient truncated toward zero and HI=remainder, with the remainder taking the sign of the dividend (signed case).
REQ-025 SHALL, for signed -2^(WIDTH-1) / -1, give LO=-2^(WIDTH-1) and HI=0.
REQ-026 SHALL, on divisor 0, still hold Busy for DIV_CYCLES cycles and leave HI and LO unchanged.
REQ-027 SHALL treat accepted MdOp 6-7 as a no-op: Busy stays 0, HI/LO unchanged.
REQ-028 SHALL use a down-counter of width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)) with states IDLE (Busy=0) and RUN (Busy=1): IDLE->RUN on accepted mult/div; RUN->IDLE when the counter expires.

Reset
REQ-029 SHALL, while reset=1, immediately force Busy=0, HI=0, LO=0 and the counter to 0, aborting any operation in progress without a HI/LO write.
REQ-030 SHALL keep Result and Zero purely combinational and unaffected by reset.
REQ-031 SHALL accept Start at the first rising edge after reset deasserts.

Verification
REQ-032 SHALL verify, with WIDTH=32 and MULT_CYCLES=5: mult A=0xFFFFFFFF, B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 SHALL verify div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 Busy cycles; divu A=7, B=0 -> HI/LO keep their prior values and Busy still lasts 10 cycles.
REQ-034 SHALL verify div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL verify that mthi A=0x1234 during Busy is ignored, and that mtlo A=0x55 at the Busy-falling edge is accepted, giving LO=0x55 in the next cycle.
REQ-036 SHALL verify that reset asserted asynchronously in cycle 3 of a mult immediately gives Busy=0, HI=0, LO=0, and that no late write occurs.
REQ-037 SHALL verify Op 8 with B=0x12345678 -> Result=0x56781234, Op 2 with A=B=0x80000000 -> Result=0, and Op 5 -> Result=0.
